rf_scoreboard_regfile: RTL and testbench

Sixteen-entry, 16-bit architectural register file with two read ports, one write port, same-cycle write-to-read bypass and a per-register pending-write scoreboard. It sits between decode (read/reserve) and writeback (write/release), replacing the raw bit-cell array view with the word-level storage the pipeline consumes. Decode uses the busy flags to stall on RAW hazards; writeback retires results through the write port.

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_pend_ctr.sv | 49 ++++
 rtl/rf_scoreboard_regfile.sv | 94 +++++++++
 tb/tb_rf_scoreboard_regfile.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared sizing constants and types for the scoreboarded register file.
//   NUM_REGS / DATA_W / ADDR_W : storage geometry (register 0 is hardwired zero)
//   reg_addr_t / reg_word_t    : register address and data word types
//   pend_cnt_t / PEND_MAX      : per-register pending-write counter type and ceiling
package rf_pkg;

  localparam int NUM_REGS = 16;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = $clog2(NUM_REGS);

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_word_t;
  typedef logic [1:0]        pend_cnt_t;

  localparam pend_cnt_t PEND_MAX = 2'd3;

endpackage

// File: rtl/rf_pend_ctr.sv
// rf_pend_ctr: saturating pending-write counter for one register.
//   clk, rst_n : clock and asynchronous active-low reset
//   inc        : a reservation for this register this cycle
//   dec        : a write to this register this cycle
//   cnt        : current number of outstanding writes (0..PEND_MAX)
//   ovf        : combinational pulse, reservation attempted while already at PEND_MAX
module rf_pend_ctr
  import rf_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      inc,
  input  logic      dec,
  output pend_cnt_t cnt,
  output logic      ovf
);

  pend_cnt_t cnt_q;
  pend_cnt_t cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf   = 1'b0;
    unique case ({inc, dec})
      2'b10: begin
        if (cnt_q == PEND_MAX) ovf = 1'b1;
        else                   cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        // An unreserved write is legal; the counter just floors at zero.
        if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
      end
      2'b11: begin
        // Reserve and retire cancel, but a write landing on an idle register
        // cannot retire the new reservation, so it still leaves one pending.
        if (cnt_q == 2'd0) cnt_d = 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/rf_scoreboard_regfile.sv
// rf_scoreboard_regfile: 16 x 16-bit register file, 2 read / 1 write ports,
// same-cycle write-to-read bypass and per-register pending-write scoreboard.
//   clk, rst_n          : clock and asynchronous active-low reset
//   wr_en/addr/data     : writeback port (also retires one pending write)
//   rd_addr1/2          : read addresses; rd_data1/2 are combinational
//   rsv_en/rsv_addr     : decode reserves a destination register
//   busy1/2             : read address still has an outstanding write
//   sb_err              : sticky flag, a reservation overflowed a counter
module rf_scoreboard_regfile
  import rf_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      wr_en,
  input  reg_addr_t wr_addr,
  input  reg_word_t wr_data,
  input  reg_addr_t rd_addr1,
  input  reg_addr_t rd_addr2,
  output reg_word_t rd_data1,
  output reg_word_t rd_data2,
  input  logic      rsv_en,
  input  reg_addr_t rsv_addr,
  output logic      busy1,
  output logic      busy2,
  output logic      sb_err
);

  reg_word_t            regs_q [NUM_REGS];
  pend_cnt_t            cnt    [NUM_REGS];
  logic [NUM_REGS-1:0]  ovf;
  logic                 sb_err_q;
  logic                 sb_err_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs_q[gi] = '0;
        assign cnt[gi]    = '0;
        assign ovf[gi]    = 1'b0;
      end else begin : g_live
        logic wr_hit;
        logic rsv_hit;
        assign wr_hit  = wr_en  && (wr_addr  == reg_addr_t'(gi));
        assign rsv_hit = rsv_en && (rsv_addr == reg_addr_t'(gi));

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n)      regs_q[gi] <= '0;
          else if (wr_hit) regs_q[gi] <= wr_data;
        end

        rf_pend_ctr u_ctr (
          .clk   (clk),
          .rst_n (rst_n),
          .inc   (rsv_hit),
          .dec   (wr_hit),
          .cnt   (cnt[gi]),
          .ovf   (ovf[gi])
        );
      end
    end
  endgenerate

  // Bypass forwards the in-flight write; register 0 always wins as zero.
  always_comb begin
    rd_data1 = regs_q[rd_addr1];
    rd_data2 = regs_q[rd_addr2];
    if (wr_en && (wr_addr == rd_addr1)) rd_data1 = wr_data;
    if (wr_en && (wr_addr == rd_addr2)) rd_data2 = wr_data;
    if (rd_addr1 == '0) rd_data1 = '0;
    if (rd_addr2 == '0) rd_data2 = '0;
  end

  // A write retiring this cycle discounts one pending entry so the hazard
  // clears in the same cycle the bypass starts supplying the data.
  always_comb begin
    pend_cnt_t h1;
    pend_cnt_t h2;
    h1 = (wr_en && (wr_addr == rd_addr1)) ? 2'd1 : 2'd0;
    h2 = (wr_en && (wr_addr == rd_addr2)) ? 2'd1 : 2'd0;
    busy1 = (rd_addr1 != '0) && (cnt[rd_addr1] > h1);
    busy2 = (rd_addr2 != '0) && (cnt[rd_addr2] > h2);
  end

  assign sb_err_d = sb_err_q | (|ovf);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_err_q <= 1'b0;
    else        sb_err_q <= sb_err_d;
  end

  assign sb_err = sb_err_q;

endmodule

// File: tb/tb_rf_scoreboard_regfile.sv
module tb_rf_scoreboard_regfile;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [3:0]  rd_addr1 = '0;
  logic [3:0]  rd_addr2 = '0;
  logic [15:0] rd_data1;
  logic [15:0] rd_data2;
  logic        rsv_en = 1'b0;
  logic [3:0]  rsv_addr = '0;
  logic        busy1;
  logic        busy2;
  logic        sb_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_scoreboard_regfile dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .busy1    (busy1),
    .busy2    (busy2),
    .sb_err   (sb_err)
  );

  typedef struct {
    logic        d_wr;
    logic [3:0]  d_wa;
    logic [15:0] d_wd;
    logic        d_rs;
    logic [3:0]  d_ra;
    logic [3:0]  d_r1;
    logic [3:0]  d_r2;
    logic [15:0] e_d1;
    logic [15:0] e_d2;
    logic        e_b1;
    logic        e_b2;
    logic        e_err;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        b1;
    logic        b2;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty actual=0 required=1");
      return;
    end
    e = sb_q.pop_front();
    cmp({e.name, ".rd_data1"}, rd_data1, e.d1);
    cmp({e.name, ".rd_data2"}, rd_data2, e.d2);
    cmp({e.name, ".busy1"}, {15'd0, busy1}, {15'd0, e.b1});
    cmp({e.name, ".busy2"}, {15'd0, busy2}, {15'd0, e.b2});
    cmp({e.name, ".sb_err"}, {15'd0, sb_err}, {15'd0, e.err});
    $display("txn %s wr=%0b@%0d=%h rsv=%0b@%0d rd=%0d/%0d -> %h %h b=%0b%0b err=%0b",
             e.name, wr_en, wr_addr, wr_data, rsv_en, rsv_addr, rd_addr1, rd_addr2,
             rd_data1, rd_data2, busy1, busy2, sb_err);
  endtask

  // Drive one cycle's inputs after the rising edge, compare mid-cycle, then let the edge pass.
  task automatic step(input string name, input vec_t v);
    exp_t e;
    wr_en    = v.d_wr;
    wr_addr  = v.d_wa;
    wr_data  = v.d_wd;
    rsv_en   = v.d_rs;
    rsv_addr = v.d_ra;
    rd_addr1 = v.d_r1;
    rd_addr2 = v.d_r2;
    e.name = name; e.d1 = v.e_d1; e.d2 = v.e_d2;
    e.b1 = v.e_b1; e.b2 = v.e_b2; e.err = v.e_err;
    sb_q.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic wr, input logic [3:0] wa, input logic [15:0] wd,
                              input logic rs, input logic [3:0] ra,
                              input logic [3:0] r1, input logic [3:0] r2,
                              input logic [15:0] d1, input logic [15:0] d2,
                              input logic b1, input logic b2, input logic err);
    vec_t v;
    v.d_wr = wr; v.d_wa = wa; v.d_wd = wd; v.d_rs = rs; v.d_ra = ra;
    v.d_r1 = r1; v.d_r2 = r2; v.e_d1 = d1; v.e_d2 = d2;
    v.e_b1 = b1; v.e_b2 = b2; v.e_err = err;
    return v;
  endfunction

  initial begin
    vec_t v;
    exp_t e;

    //                wr wa  wd        rs ra r1 r2  d1        d2        b1 b2 err
    vecs.push_back(mk(1, 3, 16'hBEEF, 0, 0, 3, 4, 16'hBEEF, 16'h0000, 0, 0, 0)); // 0 bypass r3
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 3, 3, 16'hBEEF, 16'hBEEF, 0, 0, 0)); // 1 stored r3
    vecs.push_back(mk(1, 0, 16'h1234, 0, 0, 0, 3, 16'h0000, 16'hBEEF, 0, 0, 0)); // 2 write r0
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0, 0, 0)); // 3 r0 still 0
    vecs.push_back(mk(1, 5, 16'hA5A5, 0, 0, 5, 5, 16'hA5A5, 16'hA5A5, 0, 0, 0)); // 4 bypass r5
    vecs.push_back(mk(0, 0, 16'h0000, 1, 7, 7, 5, 16'h0000, 16'hA5A5, 0, 0, 0)); // 5 rsv r7 not yet busy
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 7, 0, 16'h0000, 16'h0000, 1, 0, 0)); // 6 r7 busy
    vecs.push_back(mk(1, 7, 16'h7777, 0, 0, 7, 7, 16'h7777, 16'h7777, 0, 0, 0)); // 7 write clears busy
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 7, 0, 16'h7777, 16'h0000, 0, 0, 0)); // 8 stays clear
    vecs.push_back(mk(0, 0, 16'h0000, 1, 2, 2, 0, 16'h0000, 16'h0000, 0, 0, 0)); // 9 rsv r2 #1
    vecs.push_back(mk(0, 0, 16'h0000, 1, 2, 2, 0, 16'h0000, 16'h0000, 1, 0, 0)); // 10 rsv r2 #2
    vecs.push_back(mk(1, 2, 16'h2222, 0, 0, 2, 0, 16'h2222, 16'h0000, 1, 0, 0)); // 11 cnt2 write
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 2, 0, 16'h2222, 16'h0000, 1, 0, 0)); // 12 cnt1
    vecs.push_back(mk(1, 2, 16'h2020, 0, 0, 2, 0, 16'h2020, 16'h0000, 0, 0, 0)); // 13 second write
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 2, 0, 16'h2020, 16'h0000, 0, 0, 0)); // 14 cnt0
    vecs.push_back(mk(0, 0, 16'h0000, 1, 2, 2, 0, 16'h2020, 16'h0000, 0, 0, 0)); // 15 rsv r2 -> cnt1
    vecs.push_back(mk(1, 2, 16'h3333, 1, 2, 2, 2, 16'h3333, 16'h3333, 0, 0, 0)); // 16 rsv+wr at cnt1
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 2, 0, 16'h3333, 16'h0000, 1, 0, 0)); // 17 cnt stays 1
    vecs.push_back(mk(1, 4, 16'h4444, 1, 4, 4, 0, 16'h4444, 16'h0000, 0, 0, 0)); // 18 rsv+wr at cnt0
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 4, 0, 16'h4444, 16'h0000, 1, 0, 0)); // 19 cnt became 1
    vecs.push_back(mk(1, 4, 16'h4545, 0, 0, 4, 0, 16'h4545, 16'h0000, 0, 0, 0)); // 20 retire r4
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 4, 0, 16'h4545, 16'h0000, 0, 0, 0)); // 21 r4 idle
    vecs.push_back(mk(1, 2, 16'h5555, 1, 6, 6, 2, 16'h0000, 16'h5555, 0, 0, 0)); // 22 rsv r6 / wr r2
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 6, 2, 16'h0000, 16'h5555, 1, 0, 0)); // 23 independent
    vecs.push_back(mk(0, 0, 16'h0000, 1, 9, 9, 0, 16'h0000, 16'h0000, 0, 0, 0)); // 24 rsv r9 #1
    vecs.push_back(mk(0, 0, 16'h0000, 1, 9, 9, 0, 16'h0000, 16'h0000, 1, 0, 0)); // 25 rsv r9 #2
    vecs.push_back(mk(0, 0, 16'h0000, 1, 9, 9, 0, 16'h0000, 16'h0000, 1, 0, 0)); // 26 rsv r9 #3
    vecs.push_back(mk(0, 0, 16'h0000, 1, 9, 9, 0, 16'h0000, 16'h0000, 1, 0, 0)); // 27 rsv r9 #4 overflow
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 9, 0, 16'h0000, 16'h0000, 1, 0, 1)); // 28 sb_err set
    vecs.push_back(mk(1, 9, 16'h9999, 0, 0, 9, 0, 16'h9999, 16'h0000, 1, 0, 1)); // 29 write 1 of 3
    vecs.push_back(mk(1, 9, 16'h9998, 0, 0, 9, 0, 16'h9998, 16'h0000, 1, 0, 1)); // 30 write 2 of 3
    vecs.push_back(mk(1, 9, 16'h9997, 0, 0, 9, 0, 16'h9997, 16'h0000, 0, 0, 1)); // 31 write 3 clears
    vecs.push_back(mk(0, 0, 16'h0000, 0, 0, 9, 0, 16'h9997, 16'h0000, 0, 0, 1)); // 32 err sticky

    // Reset, release away from the clock edge.
    #12 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Every address on both ports reads zero and not busy after reset.
    for (int a = 0; a < 16; a++) begin
      v = mk(0, 0, 16'h0000, 0, 0, 4'(a), 4'(15 - a), 16'h0000, 16'h0000, 0, 0, 0);
      step($sformatf("reset_rd%0d", a), v);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      step($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset mid-cycle: outputs must clear without any clock edge.
    wr_en = 1'b0; rsv_en = 1'b0; rd_addr1 = 4'd3; rd_addr2 = 4'd9;
    #2;
    rst_n = 1'b0;
    #1;
    e.name = "async_rst"; e.d1 = 16'h0000; e.d2 = 16'h0000; e.b1 = 1'b0; e.b2 = 1'b0; e.err = 1'b0;
    sb_q.push_back(e);
    check_out();

    // A write during reset is visible only through the bypass and is then lost.
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hDEAD; rd_addr1 = 4'd3; rd_addr2 = 4'd6;
    #1;
    e.name = "rst_bypass"; e.d1 = 16'hDEAD; e.d2 = 16'h0000; e.b1 = 1'b0; e.b2 = 1'b0; e.err = 1'b0;
    sb_q.push_back(e);
    check_out();
    @(posedge clk);
    #2;
    wr_en = 1'b0;
    rst_n = 1'b1;
    #1;
    e.name = "rst_lost_wr"; e.d1 = 16'h0000; e.d2 = 16'h0000; e.b1 = 1'b0; e.b2 = 1'b0; e.err = 1'b0;
    sb_q.push_back(e);
    check_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
